// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// Each digit gets a dark BLANK slot followed by a lit SHOW slot. The digit
// code is presented to a shared external decoder, and the returned segment
// pattern is registered. New digit values are double-buffered: a load writes
// the pending register, and that value becomes active at the next frame start.
module display_scan_ctrl #(
   parameter int         N_DIGITS       = 4,
   parameter int         REFRESH_CYCLES = 50000,
   parameter int         BLANK_CYCLES   = 500,
   parameter logic [6:0] SEG_OFF        = 7'b1111111
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [4*N_DIGITS-1:0]         digits_in,
   input  logic                          load,
   output logic [3:0]                    binary_code,
   input  logic [6:0]                    display_code,
   output logic [6:0]                    seg,
   output logic [N_DIGITS-1:0]           an,
   output logic [$clog2(N_DIGITS)-1:0]   digit_sel,
   output logic                          frame_start,
   output logic                          update_done
);

   localparam int SEL_W   = $clog2(N_DIGITS);
   localparam int MAX_CYC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_DIG   = SEL_W'(N_DIGITS - 1);

   typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [SEL_W-1:0]          sel_q, sel_d;
   logic [4*N_DIGITS-1:0]     active_q, active_d;
   logic [4*N_DIGITS-1:0]     pending_q, pending_d;
   logic                      flag_q, flag_d;
   logic [6:0]                seg_q, seg_d;
   logic [N_DIGITS-1:0]       an_q, an_d;

   // Scan sequencing: OFF -> BLANK -> SHOW -> BLANK (next digit) ...
   // an/seg are computed from the next state so the registered drive lines
   // up exactly with the state it belongs to.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      an_d    = '1;
      seg_d   = SEG_OFF;
      if (!en) begin
         state_d = OFF;
         cnt_d   = '0;
         sel_d   = '0;
      end else begin
         case (state_q)
            OFF: begin
               state_d = BLANK;
               cnt_d   = '0;
               sel_d   = '0;
            end
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = SHOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            SHOW: begin
               if (cnt_q == SHOW_LAST) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  sel_d   = (sel_q == LAST_DIG) ? '0 : sel_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = OFF;
               cnt_d   = '0;
               sel_d   = '0;
            end
         endcase
      end
      // display_code already reflects this digit (binary_code is held for the
      // whole slot), so seg is valid from the first SHOW cycle.
      if (state_d == SHOW) begin
         an_d[sel_d] = 1'b0;
         seg_d       = display_code;
      end
   end

   // Frame-start update of the active digits; a coincident load bypasses the
   // pending register so the new value shows in this very frame.
   always_comb begin
      active_d  = active_q;
      pending_d = pending_q;
      flag_d    = flag_q;
      if (frame_start) begin
         if (load)
            active_d = digits_in;
         else if (flag_q)
            active_d = pending_q;
         flag_d = 1'b0;
      end else if (load) begin
         pending_d = digits_in;
         flag_d    = 1'b1;
      end
   end

   assign frame_start = (state_q == BLANK) && (cnt_q == '0) && (sel_q == '0);
   assign update_done = frame_start && (load || flag_q);
   // active_d equals active_q except on a frame start, where it is the value
   // being applied; using it keeps binary_code constant across the slot.
   assign binary_code = (state_q == OFF) ? 4'h0 : active_d[{sel_q, 2'b00} +: 4];
   assign seg         = seg_q;
   assign an          = an_q;
   assign digit_sel   = sel_q;

   // State and data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= OFF;
         cnt_q     <= '0;
         sel_q     <= '0;
         active_q  <= '0;
         pending_q <= '0;
         flag_q    <= 1'b0;
         seg_q     <= SEG_OFF;
         an_q      <= '1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         flag_q    <= flag_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a per-frame scoreboard.
module tb_display_scan_ctrl;

   localparam int         N    = 4;
   localparam int         R    = 4;
   localparam int         B    = 2;
   localparam logic [6:0] OFF7 = 7'h7F;

   logic        clk = 1'b0;
   logic        rst, en, load;
   logic [15:0] digits_in;
   logic [3:0]  binary_code;
   logic [6:0]  display_code, seg;
   logic [3:0]  an;
   logic [1:0]  digit_sel;
   logic        frame_start, update_done;

   int nchk = 0;
   int nerr = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] code;
      logic [6:0] seg;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] act_m  = '0;
   logic [15:0] pend_m = '0;
   bit          flag_m = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input logic [3:0] c);
      case (c)
         4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
      endcase
   endfunction

   // Shared decoder model.
   assign display_code = seg7(binary_code);

   display_scan_ctrl #(
      .N_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B), .SEG_OFF(OFF7)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .load(load),
      .binary_code(binary_code), .display_code(display_code), .seg(seg),
      .an(an), .digit_sel(digit_sel), .frame_start(frame_start),
      .update_done(update_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_dark(input string tag);
      check({tag, ".an"}, 32'(an), 32'hF);
      check({tag, ".seg"}, 32'(seg), 32'(OFF7));
   endtask

   // Called in the first BLANK cycle of digit 0; returns in the first BLANK
   // cycle of the following frame. Optional loads at cycle indices c0/c1.
   task automatic run_frame(input int c0, input logic [15:0] v0,
                            input int c1, input logic [15:0] v1);
      exp_t e;
      logic exp_upd;
      int   i = 0;
      e = '0;
      for (int d = 0; d < N; d++) begin
         for (int k = 0; k < B + R; k++) begin
            load = 1'b0;
            if (i == c0) begin load = 1'b1; digits_in = v0; end
            if (i == c1) begin load = 1'b1; digits_in = v1; end
            #1;
            if (i == 0) begin
               exp_upd = (c0 == 0) || flag_m;
               if (c0 == 0)    act_m = v0;
               else if (flag_m) act_m = pend_m;
               flag_m = 1'b0;
               for (int j = 0; j < N; j++)
                  sb.push_back('{an: 4'(~(4'b0001 << j)), code: act_m[4*j +: 4],
                                 seg: seg7(act_m[4*j +: 4])});
               check("frame_start", 32'(frame_start), 32'h1);
               check("update_done", 32'(update_done), 32'(exp_upd));
            end else begin
               check("frame_start_idle", 32'(frame_start), 32'h0);
               check("update_done_idle", 32'(update_done), 32'h0);
               if (load) begin pend_m = digits_in; flag_m = 1'b1; end
            end
            if (k == 0) e = sb.pop_front();
            check("digit_sel", 32'(digit_sel), 32'(d));
            check("binary_code", 32'(binary_code), 32'(e.code));
            if (k < B) begin
               check_dark("blank");
            end else begin
               check("show.an", 32'(an), 32'(e.an));
               check("show.seg", 32'(seg), 32'(e.seg));
            end
            step();
            i++;
         end
      end
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0;
      step(); step();
      // Reset state
      check_dark("rst");
      check("rst.binary_code", 32'(binary_code), 32'h0);
      check("rst.digit_sel", 32'(digit_sel), 32'h0);
      check("rst.frame_start", 32'(frame_start), 32'h0);
      check("rst.update_done", 32'(update_done), 32'h0);
      rst = 1'b0;
      step();
      check_dark("off");

      // Load while disabled, then enable
      load = 1'b1; digits_in = 16'h4321;
      step();
      load = 1'b0; pend_m = 16'h4321; flag_m = 1'b1;
      check_dark("off_loaded");
      check("off.update_done", 32'(update_done), 32'h0);
      en = 1'b1;
      step();
      run_frame(-1, '0, -1, '0);
      // Free run with wrap
      run_frame(-1, '0, -1, '0);
      // Two loads mid-frame: latest wins at the next frame start
      run_frame(3, 16'hAAAA, 10, 16'h5555);
      run_frame(-1, '0, -1, '0);
      // Load coincident with frame start bypasses pending
      run_frame(0, 16'h9876, -1, '0);

      // Disable mid-SHOW of digit 2
      for (int i = 0; i < 15; i++) step();
      check("mid_show2.an", 32'(an), 32'hB);
      check("mid_show2.sel", 32'(digit_sel), 32'h2);
      en = 1'b0;
      step();
      check_dark("disabled");
      check("disabled.sel", 32'(digit_sel), 32'h0);
      check("disabled.frame_start", 32'(frame_start), 32'h0);
      load = 1'b1; digits_in = 16'hBEEF;
      step();
      load = 1'b0; pend_m = 16'hBEEF; flag_m = 1'b1;
      step();
      check_dark("disabled2");
      check("disabled.update_done", 32'(update_done), 32'h0);
      en = 1'b1;
      step();
      run_frame(-1, '0, -1, '0);

      // Reset mid-SHOW with a load outstanding
      step();
      load = 1'b1; digits_in = 16'h1234;
      step();
      load = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check("pre_rst.an", 32'(an), 32'hD);
      #1 rst = 1'b1;
      #1;
      check_dark("async_rst");
      check("async_rst.binary_code", 32'(binary_code), 32'h0);
      check("async_rst.sel", 32'(digit_sel), 32'h0);
      check("async_rst.update_done", 32'(update_done), 32'h0);
      act_m = '0; pend_m = '0; flag_m = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      run_frame(-1, '0, -1, '0);
      run_frame(-1, '0, -1, '0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
